// File: rtl/i2c_master_seq.sv
// Single-byte I2C master sequencer: START, address+R/W, ACK, one data byte,
// ACK/NACK, STOP on an open-drain SDA with a push-pull SCL.
module i2c_master_seq #(
  parameter int QTR = 125
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  input  logic       sda_i,
  output logic       scl,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic [7:0] rdata
);

  localparam int QW = $clog2(QTR);
  localparam logic [QW-1:0] QMAX = QW'(QTR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ACK1, S_DATA, S_ACK2, S_STOP
  } state_t;

  state_t      state, state_nxt;
  logic [QW-1:0] qcnt;
  logic [1:0]  q;
  logic [2:0]  bitn;
  logic        rw_r;
  logic [6:0]  addr_r;
  logic [7:0]  wdata_r;
  logic [7:0]  rx_sh;
  logic [7:0]  frame;

  logic tick, phase_end, sample, accept;

  assign tick      = (qcnt == QMAX);
  assign phase_end = tick && (q == 2'd3);
  assign sample    = tick && (q == 2'd2);
  // The clock that pulses done is still the tail of the transaction, so a
  // start seen there is dropped rather than chaining a new command.
  assign accept    = (state == S_IDLE) && start && !done;
  assign frame     = {addr_r, rw_r};
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case leaves a signal unassigned and infers a latch.
    state_nxt = state;
    scl       = 1'b1;
    sda_oe    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        sda_oe = q[1];
        if (phase_end) state_nxt = S_ADDR;
      end
      S_ADDR: begin
        scl    = q[1];
        sda_oe = ~frame[3'd7 - bitn];
        if (phase_end && bitn == 3'd7) state_nxt = S_ACK1;
      end
      S_ACK1: begin
        scl = q[1];
        if (phase_end) state_nxt = ack_err ? S_STOP : S_DATA;
      end
      S_DATA: begin
        scl    = q[1];
        sda_oe = rw_r ? 1'b0 : ~wdata_r[3'd7 - bitn];
        if (phase_end && bitn == 3'd7) state_nxt = S_ACK2;
      end
      S_ACK2: begin
        scl = q[1];
        if (phase_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        scl    = (q != 2'd0);
        sda_oe = ~q[1];
        if (phase_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      qcnt    <= '0;
      q       <= 2'd0;
      bitn    <= 3'd0;
      rw_r    <= 1'b0;
      addr_r  <= 7'h00;
      wdata_r <= 8'h00;
      rx_sh   <= 8'h00;
      rdata   <= 8'h00;
      ack_err <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        rw_r    <= rw;
        addr_r  <= addr;
        wdata_r <= wdata;
        ack_err <= 1'b0;
        qcnt    <= '0;
        q       <= 2'd0;
        bitn    <= 3'd0;
      end else if (state != S_IDLE) begin
        qcnt <= tick ? '0 : qcnt + QW'(1);
        if (tick) q <= q + 2'd1;
        if (phase_end && (state == S_ADDR || state == S_DATA)) bitn <= bitn + 3'd1;

        // sda_i matters only on the last clock of q2, while SCL is high.
        if (sample) begin
          if (state == S_ACK1 && sda_i)          ack_err <= 1'b1;
          if (state == S_ACK2 && !rw_r && sda_i) ack_err <= 1'b1;
          if (state == S_DATA && rw_r)           rx_sh   <= {rx_sh[6:0], sda_i};
        end

        if (phase_end && state == S_DATA && rw_r && bitn == 3'd7) rdata <= rx_sh;
        if (phase_end && state == S_STOP) done <= 1'b1;
      end
    end
  end

endmodule
